// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Holds the tuse/tnew timing types, mult/div latencies and the FSM state encoding.
package pipe_ctrl_pkg;

  typedef logic [1:0] tuse_t;
  typedef logic [1:0] tnew_t;

  localparam logic [3:0] MULT_LAT = 4'd5;
  localparam logic [3:0] DIV_LAT  = 4'd10;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } pipe_state_e;

  // A source stalls when a younger producer still needs more cycles than the consumer can wait.
  function automatic logic srcHazard(input logic [4:0] src, input tuse_t tuse,
                                     input logic [4:0] eWa, input tnew_t eTnew,
                                     input logic [4:0] mWa, input tnew_t mTnew);
    return (src != 5'd0) &&
           (((src == eWa) && (eTnew > tuse)) || ((src == mWa) && (mTnew > tuse)));
  endfunction

  function automatic logic [3:0] mdLatency(input logic isDiv);
    return isDiv ? DIV_LAT : MULT_LAT;
  endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Bundle of pipeline-stage hazard inputs and stall/flush control outputs.
// The master side drives the stage information; the slave side is the controller.
interface pipe_ctrl_if;
  import pipe_ctrl_pkg::*;

  logic [4:0] d_rs;
  logic [4:0] d_rt;
  tuse_t      d_rs_tuse;
  tuse_t      d_rt_tuse;
  logic [4:0] e_wa;
  logic [4:0] m_wa;
  tnew_t      e_tnew;
  tnew_t      m_tnew;
  logic       d_is_md;
  logic       e_md_start;
  logic       e_md_div;
  logic       d_eret;
  logic       e_mtc0_epc;
  logic       m_mtc0_epc;
  logic       exc_req;

  logic       pc_we;
  logic       d_we;
  logic       e_clr;
  logic       req_out;
  logic       md_busy;

  modport master (
    output d_rs, d_rt, d_rs_tuse, d_rt_tuse, e_wa, m_wa, e_tnew, m_tnew,
           d_is_md, e_md_start, e_md_div, d_eret, e_mtc0_epc, m_mtc0_epc, exc_req,
    input  pc_we, d_we, e_clr, req_out, md_busy
  );

  modport slave (
    input  d_rs, d_rt, d_rs_tuse, d_rt_tuse, e_wa, m_wa, e_tnew, m_tnew,
           d_is_md, e_md_start, e_md_div, d_eret, e_mtc0_epc, m_mtc0_epc, exc_req,
    output pc_we, d_we, e_clr, req_out, md_busy
  );

endinterface

// File: rtl/pipe_ctrl_md_busy_cnt.sv
// Mult/div busy counter: loads the unit latency on an issue and counts down to idle.
// A new issue restarts the count; an issue squashed by an exception is ignored.
module md_busy_cnt
  import pipe_ctrl_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic start_i,
  input  logic div_i,
  input  logic kill_i,
  output logic busy_o
);

  logic [3:0] mdCnt_q;
  logic [3:0] mdCnt_d;

  always_comb begin
    mdCnt_d = mdCnt_q;
    if (start_i && !kill_i) begin
      mdCnt_d = mdLatency(div_i);
    end else if (mdCnt_q != 4'd0) begin
      mdCnt_d = mdCnt_q - 4'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mdCnt_q <= 4'd0;
    end else begin
      mdCnt_q <= mdCnt_d;
    end
  end

  assign busy_o = (mdCnt_q != 4'd0);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller: data, mult/div and ERET hazards plus exception flush FSM.
// Optional stall cycle counter port is built only when PIPE_STALL_CNT_EN is defined.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  pipe_ctrl_if.slave  bus
`ifdef PIPE_STALL_CNT_EN
  ,
  output logic [31:0] stall_cnt
`endif
);

  pipe_state_e state_q;
  logic        inFlush_q;
  logic        mdBusy;
  logic        dataHaz;
  logic        mdHaz;
  logic        eretHaz;
  logic        stall;

  md_busy_cnt u_md_busy_cnt (
    .clk     (clk),
    .reset   (reset),
    .start_i (bus.e_md_start),
    .div_i   (bus.e_md_div),
    .kill_i  (bus.exc_req),
    .busy_o  (mdBusy)
  );

  // While flushing, D and E hold bubbles, so only the mult/div unit can still block.
  always_comb begin
    dataHaz = srcHazard(bus.d_rs, bus.d_rs_tuse, bus.e_wa, bus.e_tnew, bus.m_wa, bus.m_tnew) ||
              srcHazard(bus.d_rt, bus.d_rt_tuse, bus.e_wa, bus.e_tnew, bus.m_wa, bus.m_tnew);
    eretHaz = bus.d_eret && (bus.e_mtc0_epc || bus.m_mtc0_epc);
    mdHaz   = bus.d_is_md && (mdBusy || bus.e_md_start);
    stall   = mdHaz || (!inFlush_q && (dataHaz || eretHaz));
  end

  always_comb begin
    bus.pc_we = 1'b1;
    bus.d_we  = 1'b1;
    bus.e_clr = 1'b0;
    if (!bus.exc_req && stall) begin
      bus.pc_we = 1'b0;
      bus.d_we  = 1'b0;
      bus.e_clr = 1'b1;
    end
  end

  assign bus.req_out = bus.exc_req;
  assign bus.md_busy = mdBusy;

  // A flush lasts exactly one cycle; a request arriving during it is not re-armed.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= RUN;
      inFlush_q <= 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          if (bus.exc_req) begin
            state_q   <= FLUSH;
            inFlush_q <= 1'b1;
          end
        end
        FLUSH: begin
          state_q   <= RUN;
          inFlush_q <= 1'b0;
        end
        default: begin
          state_q   <= RUN;
          inFlush_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef PIPE_STALL_CNT_EN
  logic [31:0] stallCnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stallCnt_q <= 32'd0;
    end else if (stall && !bus.exc_req) begin
      stallCnt_q <= stallCnt_q + 32'd1;
    end
  end

  assign stall_cnt = stallCnt_q;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard testbench for pipe_ctrl: directed hazard scenarios plus randomized traffic.
// Expected outputs come from a cycle-indexed reference model; a negedge monitor compares them.
module tb_pipe_ctrl;

  logic clk;
  logic reset;

  pipe_ctrl_if bus ();

`ifdef PIPE_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  pipe_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
`ifdef PIPE_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] rs, rt, eWa, mWa;
    logic [1:0] rsTuse, rtTuse, eTnew, mTnew;
    logic       isMd, mdStart, mdDiv, eret, eMtc0, mMtc0, exc;
  } stim_t;

  typedef struct {
    string       tag;
    logic        pcWe, dWe, eClr, reqOut, mdBusy;
    logic [31:0] stallCnt;
  } exp_t;

  exp_t expQ[$];
  int   testCount = 0;
  int   failCount = 0;

  int          cyc      = 0;
  int          mdEnd    = -1;
  int          flushCyc = -1;
  logic [31:0] stallCntM = 32'd0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s at t=%0t: got %0h, expected %0h", name, $time, actual, expected);
    end
  endtask

  function automatic stim_t idleStim();
    stim_t s;
    s.rs = 5'd0; s.rt = 5'd0; s.eWa = 5'd0; s.mWa = 5'd0;
    s.rsTuse = 2'd3; s.rtTuse = 2'd3; s.eTnew = 2'd0; s.mTnew = 2'd0;
    s.isMd = 1'b0; s.mdStart = 1'b0; s.mdDiv = 1'b0;
    s.eret = 1'b0; s.eMtc0 = 1'b0; s.mMtc0 = 1'b0; s.exc = 1'b0;
    return s;
  endfunction

  function automatic logic operandWaits(input logic [4:0] src, input logic [1:0] tuse, input stim_t s);
    if (src == 5'd0) return 1'b0;
    if (src == s.eWa && int'(s.eTnew) > int'(tuse)) return 1'b1;
    if (src == s.mWa && int'(s.mTnew) > int'(tuse)) return 1'b1;
    return 1'b0;
  endfunction

  task automatic driveInputs(input stim_t s);
    bus.d_rs = s.rs;          bus.d_rt = s.rt;
    bus.d_rs_tuse = s.rsTuse; bus.d_rt_tuse = s.rtTuse;
    bus.e_wa = s.eWa;         bus.m_wa = s.mWa;
    bus.e_tnew = s.eTnew;     bus.m_tnew = s.mTnew;
    bus.d_is_md = s.isMd;     bus.e_md_start = s.mdStart; bus.e_md_div = s.mdDiv;
    bus.d_eret = s.eret;      bus.e_mtc0_epc = s.eMtc0;   bus.m_mtc0_epc = s.mMtc0;
    bus.exc_req = s.exc;
  endtask

  // One clock cycle: drive, predict from the model, queue the prediction, advance the model.
  task automatic applyStimulus(input string tag, input stim_t s);
    exp_t e;
    logic busy, flushing, stall;
    driveInputs(s);
    busy     = (cyc <= mdEnd);
    flushing = (cyc == flushCyc);
    stall    = (s.isMd && (busy || s.mdStart)) ||
               (!flushing && (operandWaits(s.rs, s.rsTuse, s) || operandWaits(s.rt, s.rtTuse, s) ||
                              (s.eret && (s.eMtc0 || s.mMtc0))));
    e.tag      = tag;
    e.pcWe     = s.exc ? 1'b1 : !stall;
    e.dWe      = s.exc ? 1'b1 : !stall;
    e.eClr     = s.exc ? 1'b0 : stall;
    e.reqOut   = s.exc;
    e.mdBusy   = busy;
    e.stallCnt = stallCntM;
    expQ.push_back(e);
    @(posedge clk);
    #1;
    if (s.mdStart && !s.exc) mdEnd = cyc + (s.mdDiv ? 10 : 5);
    if (s.exc && !flushing) flushCyc = cyc + 1;
    if (stall && !s.exc) stallCntM = stallCntM + 32'd1;
    cyc++;
  endtask

  task automatic modelReset();
    mdEnd = -1;
    flushCyc = -1;
    stallCntM = 32'd0;
  endtask

  always @(negedge clk) begin
    if (expQ.size() != 0) begin
      exp_t e;
      e = expQ.pop_front();
      checkOutput({e.tag, ".pc_we"},   32'(bus.pc_we),   32'(e.pcWe));
      checkOutput({e.tag, ".d_we"},    32'(bus.d_we),    32'(e.dWe));
      checkOutput({e.tag, ".e_clr"},   32'(bus.e_clr),   32'(e.eClr));
      checkOutput({e.tag, ".req_out"}, 32'(bus.req_out), 32'(e.reqOut));
      checkOutput({e.tag, ".md_busy"}, 32'(bus.md_busy), 32'(e.mdBusy));
`ifdef PIPE_STALL_CNT_EN
      checkOutput({e.tag, ".stall_cnt"}, stall_cnt, e.stallCnt);
`endif
    end
  end

  initial begin
    stim_t s;
    reset = 1'b0;
    s = idleStim();
    driveInputs(s);
    #3;
    checkOutput("reset.md_busy", 32'(bus.md_busy), 32'd0);
    checkOutput("reset.pc_we",   32'(bus.pc_we),   32'd1);
    s.rs = 5'd5; s.rsTuse = 2'd0; s.eWa = 5'd5; s.eTnew = 2'd1;
    driveInputs(s);
    #1;
    checkOutput("reset.hazard_e_clr", 32'(bus.e_clr), 32'd1);
    s = idleStim();
    s.mdStart = 1'b1;
    driveInputs(s);
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b1;
    modelReset();
    applyStimulus("post_reset", idleStim());

    // RAW hazard on rs from E, then the same with register 0.
    s = idleStim();
    s.rs = 5'd5; s.rsTuse = 2'd0; s.eWa = 5'd5; s.eTnew = 2'd1;
    applyStimulus("raw_e", s);
    s.rs = 5'd0; s.eWa = 5'd0;
    applyStimulus("raw_r0", s);
    s = idleStim();
    s.rt = 5'd9; s.rtTuse = 2'd1; s.mWa = 5'd9; s.mTnew = 2'd2;
    applyStimulus("raw_m", s);

    // Mult latency with a waiting md consumer.
    s = idleStim();
    s.isMd = 1'b1; s.mdStart = 1'b1;
    applyStimulus("mult_start", s);
    s.mdStart = 1'b0;
    for (int i = 0; i < 7; i++) applyStimulus("mult_wait", s);

    // Div with an exception partway through the count.
    s = idleStim();
    s.mdStart = 1'b1; s.mdDiv = 1'b1;
    applyStimulus("div_start", s);
    s = idleStim();
    for (int i = 0; i < 2; i++) applyStimulus("div_run", s);
    s.exc = 1'b1;
    applyStimulus("div_exc", s);
    s = idleStim();
    for (int i = 0; i < 9; i++) applyStimulus("div_tail", s);

    // Issue squashed by a simultaneous exception.
    s = idleStim();
    s.mdStart = 1'b1; s.exc = 1'b1;
    applyStimulus("md_killed", s);
    applyStimulus("md_killed_next", idleStim());

    // ERET waiting on MTC0 EPC in M, then released.
    s = idleStim();
    s.eret = 1'b1; s.mMtc0 = 1'b1;
    applyStimulus("eret_haz", s);
    s.mMtc0 = 1'b0;
    applyStimulus("eret_free", s);

    // Asynchronous reset in the middle of a div (count 7).
    s = idleStim();
    s.mdStart = 1'b1; s.mdDiv = 1'b1;
    applyStimulus("div2_start", s);
    s = idleStim();
    for (int i = 0; i < 3; i++) applyStimulus("div2_run", s);
    checkOutput("div2_busy_before_reset", 32'(bus.md_busy), 32'd1);
    s.rs = 5'd5; s.rsTuse = 2'd0; s.eWa = 5'd5; s.eTnew = 2'd1;
    driveInputs(s);
    #1;
    reset = 1'b0;
    #1;
    checkOutput("async_reset.md_busy", 32'(bus.md_busy), 32'd0);
    checkOutput("async_reset.e_clr",   32'(bus.e_clr),   32'd1);
`ifdef PIPE_STALL_CNT_EN
    checkOutput("async_reset.stall_cnt", stall_cnt, 32'd0);
`endif
    modelReset();
    @(posedge clk);
    #2;
    reset = 1'b1;

    // Randomized traffic over a small register range to provoke collisions.
    for (int i = 0; i < 600; i++) begin
      s.rs = 5'($urandom_range(0, 3));       s.rt = 5'($urandom_range(0, 3));
      s.eWa = 5'($urandom_range(0, 3));      s.mWa = 5'($urandom_range(0, 3));
      s.rsTuse = 2'($urandom_range(0, 3));   s.rtTuse = 2'($urandom_range(0, 3));
      s.eTnew = 2'($urandom_range(0, 3));    s.mTnew = 2'($urandom_range(0, 3));
      s.isMd = ($urandom_range(0, 2) == 0);
      s.mdStart = ($urandom_range(0, 7) == 0);
      s.mdDiv = $urandom_range(0, 1) != 0;
      s.eret = ($urandom_range(0, 3) == 0);
      s.eMtc0 = ($urandom_range(0, 3) == 0);
      s.mMtc0 = ($urandom_range(0, 3) == 0);
      s.exc = ($urandom_range(0, 11) == 0);
      applyStimulus("rand", s);
    end

    applyStimulus("drain", idleStim());
    repeat (2) @(negedge clk);
    checkOutput("scoreboard_empty", 32'(expQ.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  single clock, rising edge.
REQ-002 SHALL have ports: reset  in  1  asynchronous, active-low.
REQ-003 SHALL have ports: d_rs, d_rt  in  5 each  D-stage source register numbers.
REQ-004 SHALL have ports: d_rs_tuse, d_rt_tuse  in  2 each  cycles until D operand is needed (3 = unused).
REQ-005 SHALL have ports: e_wa, m_wa  in  5 each  E/M destination register numbers.
REQ-006 SHALL have ports: e_tnew, m_tnew  in  2 each  cycles until E/M result is ready.
REQ-007 SHALL have ports: d_is_md  in  1  D instruction uses the mult/div unit or HI/LO.
REQ-008 SHALL have ports: e_md_start  in  1  mult/div issued in E this cycle; e_md_div  in  1  issued op is div.
REQ-009 SHALL have ports: d_eret  in  1  ERET in D; e_mtc0_epc, m_mtc0_epc  in  1 each  MTC0 to EPC in E/M.
REQ-010 SHALL have ports: exc_req  in  1  exception/interrupt request from CP0.
REQ-011 SHALL have ports: pc_we, d_we  out  1 each  PC and D-register write enables.
REQ-012 SHALL have ports: e_clr  out  1  bubble into E register; req_out  out  1  flush all pipeline registers to handler.
REQ-013 SHALL have ports: md_busy  out  1  mult/div unit busy.
REQ-014 SHALL have ports: stall_cnt  out  32  stall cycle count (present only under PIPE_STALL_CNT_EN).

Function
REQ-015 SHALL compute data hazard: for src in {rs,rt}: src!=0 && ((src==e_wa && e_tnew>tuse) || (src==m_wa && m_tnew>tuse)).
REQ-016 SHALL compute md hazard: d_is_md && (md_busy || e_md_start).
REQ-017 SHALL compute eret hazard: d_eret && (e_mtc0_epc || m_mtc0_epc).
REQ-018 SHALL assert stall = OR of REQ-015..017, combinationally, same cycle.
REQ-019 SHALL drive on stall: pc_we=0, d_we=0, e_clr=1; otherwise pc_we=1, d_we=1, e_clr=0.
REQ-020 SHALL drive req_out=exc_req combinationally; when exc_req=1, SHALL force pc_we=1, d_we=1, e_clr=0 regardless of stall.
REQ-021 SHALL load 4-bit md counter on e_md_start: 5 for mult, 10 for div; else decrement if nonzero, saturating at 0.
REQ-022 SHALL drive md_busy = (counter!=0).
REQ-023 SHALL ignore e_md_start when exc_req=1 in the same cycle (flushed instruction); an already-running count SHALL continue.
REQ-024 SHALL use FSM RUN -> FLUSH on exc_req; FLUSH -> RUN unconditionally after one cycle.
REQ-025 SHALL suppress data and eret hazards in FLUSH (pipeline holds bubbles); md hazard SHALL remain active.
REQ-026 SHALL restart the count from the new value if e_md_start arrives while busy (no stacking).

Reset
REQ-027 SHALL, while reset=0, asynchronously clear counter to 0, FSM to RUN, stall_cnt to 0; outputs then: md_busy=0, and pc_we/d_we/e_clr/req_out follow REQ-019/020 from inputs.
REQ-028 SHALL leave reset synchronously on the first rising edge after reset=1 with no spurious counter load.

Configuration
REQ-029 SHALL, with PIPE_STALL_CNT_EN defined, provide stall_cnt incrementing by 1 (wrapping at 2^32) each cycle where stall=1 and exc_req=0.
REQ-030 SHALL, without PIPE_STALL_CNT_EN, omit the stall_cnt port and its register entirely.

Structure
REQ-031 SHALL place in package pipe_ctrl_pkg: tuse/tnew 2-bit type, MULT_LAT=5, DIV_LAT=10, FSM state enum {RUN, FLUSH}.
REQ-032 SHALL implement the counter (REQ-021..023, 026) as sub-module md_busy_cnt; hazard logic and FSM stay in pipe_ctrl.

Verification
REQ-033 SHALL cover: d_rs=5, d_rs_tuse=0, e_wa=5, e_tnew=1 -> pc_we=0, d_we=0, e_clr=1 that cycle; d_rs=0 same case -> no stall.
REQ-034 SHALL cover: e_md_start=1, e_md_div=0 -> md_busy high 5 cycles; d_is_md=1 throughout -> stall 6 cycles (start cycle + 5), released on the 7th.
REQ-035 SHALL cover: div start, then exc_req at busy cycle 3 -> req_out=1, pc_we=1, e_clr=0 that cycle, md_busy stays high until 10 cycles elapsed.
REQ-036 SHALL cover: e_md_start and exc_req same cycle -> counter stays 0, md_busy=0 next cycle.
REQ-037 SHALL cover: d_eret=1, m_mtc0_epc=1 -> stall; next cycle m_mtc0_epc=0 -> stall released.
REQ-038 SHALL cover: reset=0 mid-div (count 7) -> md_busy=0 immediately, without waiting for clk; FSM RUN; stall_cnt=0 if enabled.
